// File: rtl/comparator_strobe_ctrl_pkg.sv
// Shared definitions for the comparator strobe controller: default field
// widths and the controller state encoding.
package comparator_strobe_ctrl_pkg;

  localparam int DEF_PH_W = 4;
  localparam int DEF_TO_W = 6;
  localparam int DEF_NV_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRECH = 3'd1,
    ST_EVAL  = 3'd2,
    ST_TALLY = 3'd3,
    ST_DONE  = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/comparator_strobe_ctrl_sync2.sv
// Two-flop synchroniser for signals arriving asynchronously to clk.
module comparator_sync2 #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/comparator_strobe_ctrl.sv
// Strobe generator and capture logic for a dynamic comparator. Runs N
// precharge/evaluate strobes per request, majority-votes the latched
// decisions and hands one result back to the consumer.
//
// Handshakes: a transfer happens on a rising CLK edge where valid and ready
// are both high. start_ready_o is high only while idle; res_valid_o, once
// high, stays high with stable data until the edge where res_ready_i is seen.
module comparator_strobe_ctrl
  import comparator_strobe_ctrl_pkg::*;
#(
  parameter int PH_W = DEF_PH_W,
  parameter int TO_W = DEF_TO_W,
  parameter int NV_W = DEF_NV_W
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            start_valid_i,
  output logic            start_ready_o,
  input  logic [PH_W-1:0] prech_len_i,
  input  logic [TO_W-1:0] eval_max_i,
  input  logic [NV_W-1:0] n_votes_i,
  output logic            CmpClk,
  output logic            CmpClkBar,
  input  logic            Outp,
  input  logic            Outn,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic            res_bit_o,
  output logic [NV_W-1:0] res_ones_o,
  output logic            res_timeout_o,
  output ctrl_state_t     dbg_state
);

  ctrl_state_t     state;
  logic [PH_W-1:0] prech_len_q;
  logic [TO_W-1:0] eval_max_q;
  logic [NV_W-1:0] n_votes_q;
  logic [PH_W-1:0] ph_cnt;
  logic [TO_W-1:0] eval_cnt;
  logic [NV_W-1:0] vote_cnt;
  logic [NV_W-1:0] ones;
  logic            timeout_flag;

  logic [1:0]      cmp_sync;
  logic            sync_p;
  logic            sync_n;
  logic            decided;
  logic [TO_W:0]   eval_cnt_inc;
  logic            majority;

  comparator_sync2 #(.W(2)) u_sync (
    .clk  (CLK),
    .rstn (RSTN),
    .d    ({Outp, Outn}),
    .q    (cmp_sync)
  );

  // 00 is the precharged state and 11 is illegal; only a split pair counts.
  assign sync_p  = cmp_sync[1];
  assign sync_n  = cmp_sync[0];
  assign decided = sync_p ^ sync_n;

  assign eval_cnt_inc = {1'b0, eval_cnt} + {{TO_W{1'b0}}, 1'b1};

  // Strict majority in one extra bit so 2*ones cannot wrap; ties resolve to 0.
  assign majority = ({ones, 1'b0} > {1'b0, n_votes_q});

  assign start_ready_o = (state == ST_IDLE);
  assign dbg_state     = state;

  // Conversion sequencer: precharge, evaluate, tally per strobe, then result.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state         <= ST_IDLE;
      CmpClk        <= 1'b0;
      CmpClkBar     <= 1'b1;
      prech_len_q   <= '0;
      eval_max_q    <= '0;
      n_votes_q     <= '0;
      ph_cnt        <= '0;
      eval_cnt      <= '0;
      vote_cnt      <= '0;
      ones          <= '0;
      timeout_flag  <= 1'b0;
      res_valid_o   <= 1'b0;
      res_bit_o     <= 1'b0;
      res_ones_o    <= '0;
      res_timeout_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid_i) begin
            prech_len_q  <= prech_len_i;
            eval_max_q   <= (eval_max_i == '0) ? TO_W'(1) : eval_max_i;
            n_votes_q    <= (n_votes_i == '0) ? NV_W'(1) : n_votes_i;
            vote_cnt     <= (n_votes_i == '0) ? NV_W'(1) : n_votes_i;
            ones         <= '0;
            timeout_flag <= 1'b0;
            ph_cnt       <= '0;
            state        <= ST_PRECH;
          end
        end
        ST_PRECH: begin
          if (ph_cnt == prech_len_q) begin
            eval_cnt  <= '0;
            CmpClk    <= 1'b1;
            CmpClkBar <= 1'b0;
            state     <= ST_EVAL;
          end else begin
            ph_cnt <= ph_cnt + PH_W'(1);
          end
        end
        ST_EVAL: begin
          // A decision arriving on the timeout cycle still counts as decided.
          if (decided) begin
            ones      <= ones + NV_W'(sync_p);
            CmpClk    <= 1'b0;
            CmpClkBar <= 1'b1;
            state     <= ST_TALLY;
          end else if (eval_cnt_inc == {1'b0, eval_max_q}) begin
            timeout_flag <= 1'b1;
            CmpClk       <= 1'b0;
            CmpClkBar    <= 1'b1;
            state        <= ST_TALLY;
          end else begin
            eval_cnt <= eval_cnt_inc[TO_W-1:0];
          end
        end
        ST_TALLY: begin
          vote_cnt <= vote_cnt - NV_W'(1);
          if (vote_cnt != NV_W'(1)) begin
            ph_cnt <= '0;
            state  <= ST_PRECH;
          end else begin
            res_valid_o   <= 1'b1;
            res_bit_o     <= majority;
            res_ones_o    <= ones;
            res_timeout_o <= timeout_flag;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_strobe_ctrl.sv
// Bench for comparator_strobe_ctrl: a behavioural comparator drives Outp/Outn
// from a per-strobe plan, and each request's result, latency, strobe count
// and evaluate time are predicted from the plan with plain arithmetic.
module tb_comparator_strobe_ctrl;
  import comparator_strobe_ctrl_pkg::*;

  localparam int PH_W = 4;
  localparam int TO_W = 6;
  localparam int NV_W = 4;

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic            start_valid_i = 1'b0;
  logic            start_ready_o;
  logic [PH_W-1:0] prech_len_i = '0;
  logic [TO_W-1:0] eval_max_i = '0;
  logic [NV_W-1:0] n_votes_i = '0;
  logic            CmpClk;
  logic            CmpClkBar;
  logic            Outp = 1'b0;
  logic            Outn = 1'b0;
  logic            res_valid_o;
  logic            res_ready_i = 1'b0;
  logic            res_bit_o;
  logic [NV_W-1:0] res_ones_o;
  logic            res_timeout_o;
  ctrl_state_t     dbg_state;

  comparator_strobe_ctrl #(.PH_W(PH_W), .TO_W(TO_W), .NV_W(NV_W)) dut (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .start_valid_i (start_valid_i),
    .start_ready_o (start_ready_o),
    .prech_len_i   (prech_len_i),
    .eval_max_i    (eval_max_i),
    .n_votes_i     (n_votes_i),
    .CmpClk        (CmpClk),
    .CmpClkBar     (CmpClkBar),
    .Outp          (Outp),
    .Outn          (Outn),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_bit_o     (res_bit_o),
    .res_ones_o    (res_ones_o),
    .res_timeout_o (res_timeout_o),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- comparator model ----------------
  // plan_d: negedges after CmpClk rise at which the comparator resolves (0 = never)
  // plan_v: 0 = Outn wins, 1 = Outp wins, 2 = illegal 11
  int plan_d[16];
  int plan_v[16];
  int sidx    = 0;
  int ecyc    = 0;
  int pulses  = 0;
  int hi_cyc  = 0;
  int bar_err = 0;
  bit prev_clk = 1'b0;
  bit mon_en   = 1'b0;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (CmpClkBar !== ~CmpClk) bar_err++;
      if (CmpClk === 1'b1) begin
        if (!prev_clk) pulses++;
        hi_cyc++;
        ecyc++;
        if (sidx < 16 && plan_d[sidx] != 0 && ecyc == plan_d[sidx]) begin
          case (plan_v[sidx])
            0:       begin Outp = 1'b0; Outn = 1'b1; end
            1:       begin Outp = 1'b1; Outn = 1'b0; end
            default: begin Outp = 1'b1; Outn = 1'b1; end
          endcase
        end
      end else begin
        if (prev_clk) sidx++;
        ecyc = 0;
        Outp = 1'b0;
        Outn = 1'b0;
      end
      prev_clk = CmpClk;
    end
  end

  // ---------------- driver + reference ----------------
  task automatic run_req(input string tag, input int p, input int em, input int nv,
                         input int hold);
    int nv_e, em_e, exp_ones, exp_to, exp_lat, exp_hi, ca, waited, exp_bit;
    nv_e = (nv == 0) ? 1 : nv;
    em_e = (em == 0) ? 1 : em;
    exp_ones = 0; exp_to = 0; exp_lat = 0; exp_hi = 0;
    for (int i = 0; i < nv_e; i++) begin
      bit dec;
      int ev;
      // Decision reaches the controller two sync edges after the comparator settles.
      dec = (plan_d[i] != 0) && (plan_v[i] != 2) && (plan_d[i] + 2 <= em_e);
      ev  = dec ? plan_d[i] + 2 : em_e;
      if (dec && plan_v[i] == 1) exp_ones++;
      if (!dec) exp_to = 1;
      exp_lat += (p + 1) + ev + 1;
      exp_hi  += ev;
    end
    exp_bit = (2 * exp_ones > nv_e) ? 1 : 0;

    waited = 0;
    while (start_ready_o !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, "_start_ready"}, 32'(start_ready_o), 32'd1);

    sidx = 0; pulses = 0; hi_cyc = 0;
    start_valid_i = 1'b1;
    prech_len_i   = PH_W'(p);
    eval_max_i    = TO_W'(em);
    n_votes_i     = NV_W'(nv);
    @(posedge CLK);
    @(negedge CLK);
    ca = cyc;
    start_valid_i = 1'b0;

    waited = 0;
    while (res_valid_o !== 1'b1 && waited < 3000) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, "_valid_seen"}, 32'(res_valid_o), 32'd1);
    check({tag, "_latency"}, 32'(cyc - ca), 32'(exp_lat));
    check({tag, "_bit"}, 32'(res_bit_o), 32'(exp_bit));
    check({tag, "_ones"}, 32'(res_ones_o), 32'(exp_ones));
    check({tag, "_timeout"}, 32'(res_timeout_o), 32'(exp_to));
    check({tag, "_pulses"}, 32'(pulses), 32'(nv_e));
    check({tag, "_eval_cycles"}, 32'(hi_cyc), 32'(exp_hi));

    if (hold > 0) begin
      // Consumer stalls while a new request is pending: nothing may move.
      start_valid_i = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        check({tag, "_hold_valid"}, 32'(res_valid_o), 32'd1);
        check({tag, "_hold_data"}, 32'({res_bit_o, res_ones_o, res_timeout_o}),
              32'({exp_bit[0], NV_W'(exp_ones), exp_to[0]}));
        check({tag, "_hold_start_ready"}, 32'(start_ready_o), 32'd0);
      end
      res_ready_i = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      res_ready_i = 1'b0;
      check({tag, "_bubble_valid"}, 32'(res_valid_o), 32'd0);
      check({tag, "_bubble_ready"}, 32'(start_ready_o), 32'd1);
      check({tag, "_bubble_idle"}, 32'(dbg_state), 32'(ST_IDLE));
      @(posedge CLK);
      @(negedge CLK);
      start_valid_i = 1'b0;
      check({tag, "_accept_after_bubble"}, 32'(start_ready_o), 32'd0);
      // Abandon the request accepted above.
      RSTN = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
    end else begin
      res_ready_i = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      res_ready_i = 1'b0;
      check({tag, "_drop_valid"}, 32'(res_valid_o), 32'd0);
    end
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) begin
      plan_d[i] = 0;
      plan_v[i] = 0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waited, seen;
    clear_plan();
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmpclk", 32'(CmpClk), 32'd0);
    check("rst_cmpclkbar", 32'(CmpClkBar), 32'd1);
    check("rst_valid", 32'(res_valid_o), 32'd0);
    check("rst_bit", 32'(res_bit_o), 32'd0);
    check("rst_ones", 32'(res_ones_o), 32'd0);
    check("rst_timeout", 32'(res_timeout_o), 32'd0);
    check("rst_start_ready", 32'(start_ready_o), 32'd1);
    RSTN = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);

    // single vote, P=2, decision 3 negedges into evaluate
    clear_plan(); plan_d[0] = 3; plan_v[0] = 1;
    run_req("one_vote", 2, 20, 1, 0);

    // five votes: P N P P N
    clear_plan();
    plan_d[0] = 1; plan_v[0] = 1;
    plan_d[1] = 2; plan_v[1] = 0;
    plan_d[2] = 3; plan_v[2] = 1;
    plan_d[3] = 1; plan_v[3] = 1;
    plan_d[4] = 2; plan_v[4] = 0;
    run_req("five_votes", 1, 10, 5, 0);

    // four votes, tie
    clear_plan();
    plan_d[0] = 1; plan_v[0] = 1;
    plan_d[1] = 1; plan_v[1] = 0;
    plan_d[2] = 2; plan_v[2] = 1;
    plan_d[3] = 2; plan_v[3] = 0;
    run_req("tie", 0, 8, 4, 0);

    // no decision: timeout after 4 cycles, and eval_max=0 behaves as 1
    clear_plan();
    run_req("timeout4", 3, 4, 1, 0);
    run_req("timeout0", 0, 0, 1, 0);

    // illegal 11 stays undecided
    clear_plan(); plan_d[0] = 1; plan_v[0] = 2;
    run_req("both_high", 1, 5, 1, 0);

    // n_votes=0 behaves as 1
    clear_plan(); plan_d[0] = 1; plan_v[0] = 1;
    run_req("nvotes0", 0, 6, 0, 0);

    // consumer stall for 10 cycles
    clear_plan(); plan_d[0] = 2; plan_v[0] = 1;
    run_req("stall", 1, 9, 1, 10);

    // reset while CmpClk is high
    clear_plan();
    sidx = 0;
    start_valid_i = 1'b1; prech_len_i = 4'd1; eval_max_i = 6'd60; n_votes_i = 4'd1;
    @(posedge CLK);
    @(negedge CLK);
    start_valid_i = 1'b0;
    waited = 0;
    while (CmpClk !== 1'b1 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    check("mid_eval_reached", 32'(CmpClk), 32'd1);
    RSTN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    check("mid_rst_cmpclk", 32'(CmpClk), 32'd0);
    check("mid_rst_cmpclkbar", 32'(CmpClkBar), 32'd1);
    check("mid_rst_valid", 32'(res_valid_o), 32'd0);
    check("mid_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
    seen = 0;
    repeat (80) begin
      @(negedge CLK);
      if (res_valid_o === 1'b1 || CmpClk === 1'b1) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);

    // randomized requests
    for (int r = 0; r < 25; r++) begin
      int p, em, nv, em_e;
      p  = $urandom_range(0, 15);
      em = $urandom_range(0, 12);
      nv = $urandom_range(0, 6);
      em_e = (em == 0) ? 1 : em;
      clear_plan();
      for (int i = 0; i < 16; i++) begin
        plan_d[i] = $urandom_range(0, 6);
        plan_v[i] = $urandom_range(0, 2);
        // keep decision and timeout from landing on the same edge
        if (plan_d[i] + 2 == em_e) plan_d[i] = 0;
      end
      run_req($sformatf("rnd%0d", r), p, em, nv, $urandom_range(0, 3) == 0 ? 2 : 0);
    end

    check("cmpclkbar_complement_errs", 32'(bar_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
